riscv_multicycle_core: RTL and testbench

- Parametrised next-generation multicycle RV32 integer core for the matrix-vector workloads. Uses an IF/ID/EX/MEM/WB state machine with internal instruction and data memories.
- Adds the following over the current core: async reset, start/done handshake, correct sign-extended immediates and PC-relative branch targets, full branch set, JAL, x0 hardwiring, error halt, configurable memory depths and counter widths.
- Sits under the testbench/top as the compute engine. The host loads memories via $readmemb and reads results through the debug ports.

---
 rtl/riscv_multicycle_core.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_riscv_multicycle_core.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32 integer core (IF/ID/EX/MEM/WB) with internal instruction and data memories,
// start/done handshake, error halt and saturating cycle/retire counters.
module riscv_multicycle_core #(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_BYTES = 4096,
    parameter int unsigned CNT_W      = 32,
    parameter logic [31:0] EOF_WORD   = 32'h1111_1111,
    parameter              IMEM_FILE  = "IMemory.txt",
    parameter              DMEM_FILE  = "DMemory.txt"
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          done,
    output logic                          err,
    output logic [CNT_W-1:0]              cycle_count,
    output logic [CNT_W-1:0]              instr_count,
    input  logic [4:0]                    dbg_reg_sel,
    output logic [31:0]                   dbg_reg_data,
    input  logic [$clog2(DMEM_BYTES)-1:0] host_addr,
    output logic [31:0]                   host_rdata
);

    localparam int unsigned IW = $clog2(IMEM_WORDS);
    localparam int unsigned AW = $clog2(DMEM_BYTES);
    localparam logic [32:0] IMEM_LIMIT = 33'(4 * IMEM_WORDS);
    localparam logic [32:0] DMEM_LIMIT = 33'(DMEM_BYTES);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    logic [31:0] imem [IMEM_WORDS];
    logic [7:0]  dmem [DMEM_BYTES];
    logic [31:0] rf_q [32];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        dmem_we;
    logic        retire;
    logic        clear;
    logic        bad;
    logic        taken;
    logic        mem_bad;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    logic [AW-1:0] ma0, ma1, ma2, ma3;
    logic [AW-1:0] ha0, ha1, ha2, ha3;
    logic [31:0]   dmem_rword;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Big-endian word packing: most significant byte at the lowest address.
    assign ma0 = alu_q[AW-1:0];
    assign ma1 = ma0 + AW'(1);
    assign ma2 = ma0 + AW'(2);
    assign ma3 = ma0 + AW'(3);
    assign dmem_rword = {dmem[ma0], dmem[ma1], dmem[ma2], dmem[ma3]};

    assign ha0 = host_addr;
    assign ha1 = host_addr + AW'(1);
    assign ha2 = host_addr + AW'(2);
    assign ha3 = host_addr + AW'(3);
    assign host_rdata = {dmem[ha0], dmem[ha1], dmem[ha2], dmem[ha3]};

    assign mem_bad = (alu_q[1:0] != 2'b00) || (({1'b0, alu_q} + 33'd3) >= DMEM_LIMIT);

    assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? '0 : rf_q[dbg_reg_sel];
    assign done         = done_q;
    assign err          = err_q;
    assign cycle_count  = cyc_q;
    assign instr_count  = ret_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        done_d  = done_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        rf_we   = 1'b0;
        rf_wa   = rd;
        rf_wd   = '0;
        dmem_we = 1'b0;
        retire  = 1'b0;
        clear   = 1'b0;
        bad     = 1'b0;
        taken   = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_IF;
                    pc_d    = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    clear   = 1'b1;
                end
            end
            S_IF: begin
                if (({1'b0, pc_q} >= IMEM_LIMIT) || (pc_q[1:0] != 2'b00)) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    ir_d    = imem[pc_q[IW+1:2]];
                    pc_d    = pc_q + 32'd4;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (ir_q == EOF_WORD) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    rs1_d   = rf_q[rs1];
                    rs2_d   = rf_q[rs2];
                    alu_d   = (pc_q - 32'd4) + ((opcode == OP_JAL) ? imm_j : imm_b);
                    state_d = S_EX;
                end
            end
            S_EX: begin
                state_d = S_MEM;
                case (opcode)
                    OP_R: begin
                        case ({f7, f3})
                            {7'b0000000, 3'b000}: alu_d = rs1_q + rs2_q;
                            {7'b0100000, 3'b000}: alu_d = rs1_q - rs2_q;
                            {7'b0000001, 3'b000}: alu_d = rs1_q * rs2_q;
                            {7'b0000000, 3'b001}: alu_d = rs1_q << rs2_q[4:0];
                            {7'b0000000, 3'b010}: alu_d = {31'b0, $signed(rs1_q) < $signed(rs2_q)};
                            {7'b0000000, 3'b100}: alu_d = rs1_q ^ rs2_q;
                            {7'b0000000, 3'b110}: alu_d = rs1_q | rs2_q;
                            {7'b0000000, 3'b111}: alu_d = rs1_q & rs2_q;
                            default:              bad   = 1'b1;
                        endcase
                    end
                    OP_I: begin
                        if (f3 == 3'b000)                     alu_d = rs1_q + imm_i;
                        else if (f3 == 3'b001 && f7 == 7'd0)  alu_d = rs1_q << ir_q[24:20];
                        else                                  bad   = 1'b1;
                    end
                    OP_LW: begin
                        if (f3 == 3'b010) alu_d = rs1_q + imm_i;
                        else              bad   = 1'b1;
                    end
                    OP_SW: begin
                        if (f3 == 3'b010) alu_d = rs1_q + imm_s;
                        else              bad   = 1'b1;
                    end
                    OP_LUI: alu_d = {ir_q[31:12], 12'b0};
                    OP_BR: begin
                        case (f3)
                            3'b000:  taken = (rs1_q == rs2_q);
                            3'b001:  taken = (rs1_q != rs2_q);
                            3'b100:  taken = ($signed(rs1_q) < $signed(rs2_q));
                            3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
                            default: bad   = 1'b1;
                        endcase
                        if (!bad) begin
                            if (taken) pc_d = alu_q;
                            retire  = 1'b1;
                            state_d = S_IF;
                        end
                    end
                    OP_JAL: begin
                        rf_we   = 1'b1;
                        rf_wd   = pc_q;
                        pc_d    = alu_q;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                    default: bad = 1'b1;
                endcase
                if (bad) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_MEM: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    if (mem_bad) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (opcode == OP_SW) begin
                        dmem_we = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        mdr_d   = dmem_rword;
                        state_d = S_WB;
                    end
                end else begin
                    rf_we   = 1'b1;
                    rf_wd   = alu_q;
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wd   = mdr_q;
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_IDLE;
        endcase

        // The cycle that ends a run (transition into HALT) is not charged to cycle_count.
        if (clear) begin
            cyc_d = '0;
            ret_d = '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT && state_d != S_HALT && !(&cyc_q))
                cyc_d = cyc_q + 1'b1;
            if (retire && !(&ret_q))
                ret_d = ret_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && rf_wa != 5'd0) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // Memory has no reset; an async reset during MEM drops state_q before the edge, so no write occurs.
    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[ma0] <= rs2_q[31:24];
            dmem[ma1] <= rs2_q[23:16];
            dmem[ma2] <= rs2_q[15:8];
            dmem[ma3] <= rs2_q[7:0];
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: assembles small programs into IMEM, runs them,
// and compares registers, memory words and counters against a scoreboard of expected values.
module tb_riscv_multicycle_core;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [31:0] EOF_W = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done;
    logic        err;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [4:0]  dbg_reg_sel;
    logic [31:0] dbg_reg_data;
    logic [11:0] host_addr;
    logic [31:0] host_rdata;

    riscv_multicycle_core #(
        .IMEM_WORDS (1024),
        .DMEM_BYTES (4096),
        .CNT_W      (32),
        .EOF_WORD   (32'h1111_1111)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .done         (done),
        .err          (err),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count),
        .dbg_reg_sel  (dbg_reg_sel),
        .dbg_reg_data (dbg_reg_data),
        .host_addr    (host_addr),
        .host_rdata   (host_rdata)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {K_REG, K_WORD, K_BYTE, K_DONE, K_ERR, K_CYC, K_INS} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    string       sb_tag[$];
    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned tot_cnt  = 0;
    logic [9:0]  wp;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] i_t(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(input int imm, input logic [4:0] rd);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic emit(input logic [31:0] w);
        dut.imem[wp] = w;
        wp = wp + 10'd1;
    endtask

    task automatic exp_v(input string tag, input kind_t k, input logic [31:0] sel, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic check_all();
        exp_t        e;
        string       t;
        logic [31:0] obs;
        logic [31:0] w;
        int          sh;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            t   = sb_tag.pop_front();
            obs = '0;
            case (e.kind)
                K_REG:  begin dbg_reg_sel = e.sel[4:0]; #1; obs = dbg_reg_data; end
                K_WORD: begin host_addr = e.sel[11:0]; #1; obs = host_rdata; end
                K_BYTE: begin
                    host_addr = {e.sel[11:2], 2'b00};
                    #1;
                    w   = host_rdata;
                    sh  = 8 * (3 - int'(e.sel[1:0]));
                    obs = (w >> sh) & 32'h0000_00FF;
                end
                K_DONE: obs = {31'b0, done};
                K_ERR:  obs = {31'b0, err};
                K_CYC:  obs = cycle_count;
                K_INS:  obs = instr_count;
                default: obs = 'x;
            endcase
            tot_cnt++;
            assert (obs === e.exp) pass_cnt++;
            else begin
                fail_cnt++;
                $error("FAIL %s: got 0x%08h expected 0x%08h", t, obs, e.exp);
            end
        end
    endtask

    task automatic run(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        tot_cnt++;
        assert (done === 1'b1) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s_done: got %b expected 1", tag, done);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        dbg_reg_sel = '0;
        host_addr   = '0;
        wp          = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_v("rst_done", K_DONE, 0, 0);
        exp_v("rst_err",  K_ERR,  0, 0);
        exp_v("rst_cyc",  K_CYC,  0, 0);
        exp_v("rst_ins",  K_INS,  0, 0);
        exp_v("rst_x1",   K_REG,  1, 0);
        check_all();

        // Arithmetic: addi/add/sub/mul then EOF
        wp = '0;
        emit(i_t(5, 0, 3'b000, 1, OP_I));
        emit(i_t(-3, 0, 3'b000, 2, OP_I));
        emit(r_t(7'b0000000, 2, 1, 3'b000, 3));
        emit(r_t(7'b0100000, 2, 1, 3'b000, 4));
        emit(r_t(7'b0000001, 2, 1, 3'b000, 5));
        emit(EOF_W);
        exp_v("alu_err", K_ERR, 0, 0);
        exp_v("alu_x2",  K_REG, 2, 32'hFFFF_FFFD);
        exp_v("alu_x3",  K_REG, 3, 32'd2);
        exp_v("alu_x4",  K_REG, 4, 32'd8);
        exp_v("alu_x5",  K_REG, 5, 32'hFFFF_FFF1);
        exp_v("alu_ins", K_INS, 0, 32'd5);
        exp_v("alu_cyc", K_CYC, 0, 32'd21);
        run("alu");
        check_all();

        // Store/load big-endian, plus store at the last legal word of DMEM
        wp = '0;
        emit(u_t(20'hA1B2C, 1));
        emit(i_t(32'h3D4, 1, 3'b000, 1, OP_I));
        emit(s_t(8, 1, 0));
        emit(i_t(8, 0, 3'b010, 6, OP_LW));
        emit(u_t(20'h00001, 12));
        emit(s_t(-4, 1, 12));
        emit(EOF_W);
        exp_v("mem_err",   K_ERR,  0, 0);
        exp_v("mem_word8", K_WORD, 8, 32'hA1B2_C3D4);
        exp_v("mem_b8",    K_BYTE, 8, 32'hA1);
        exp_v("mem_b9",    K_BYTE, 9, 32'hB2);
        exp_v("mem_b10",   K_BYTE, 10, 32'hC3);
        exp_v("mem_b11",   K_BYTE, 11, 32'hD4);
        exp_v("mem_x6",    K_REG,  6, 32'hA1B2_C3D4);
        exp_v("mem_top",   K_WORD, 4092, 32'hA1B2_C3D4);
        exp_v("mem_ins",   K_INS,  0, 32'd6);
        exp_v("mem_cyc",   K_CYC,  0, 32'd26);
        run("mem");
        check_all();

        // Counted loop with backward blt
        wp = '0;
        emit(i_t(0, 0, 3'b000, 1, OP_I));
        emit(i_t(4, 0, 3'b000, 2, OP_I));
        emit(i_t(1, 1, 3'b000, 1, OP_I));
        emit(b_t(-4, 2, 1, 3'b100));
        emit(EOF_W);
        exp_v("loop_err", K_ERR, 0, 0);
        exp_v("loop_x1",  K_REG, 1, 32'd4);
        exp_v("loop_ins", K_INS, 0, 32'd10);
        exp_v("loop_cyc", K_CYC, 0, 32'd37);
        run("loop");
        check_all();

        // JAL forward and writes to x0
        wp = '0;
        emit(j_t(12, 7));
        emit(i_t(1, 0, 3'b000, 8, OP_I));
        emit(i_t(2, 0, 3'b000, 8, OP_I));
        emit(i_t(9, 0, 3'b000, 0, OP_I));
        emit(i_t(3, 0, 3'b000, 9, OP_I));
        emit(EOF_W);
        exp_v("jal_err", K_ERR, 0, 0);
        exp_v("jal_x7",  K_REG, 7, 32'd4);
        exp_v("jal_x8",  K_REG, 8, 32'd0);
        exp_v("jal_x0",  K_REG, 0, 32'd0);
        exp_v("jal_x9",  K_REG, 9, 32'd3);
        exp_v("jal_ins", K_INS, 0, 32'd3);
        exp_v("jal_cyc", K_CYC, 0, 32'd12);
        run("jal");
        check_all();

        // Misaligned load halts with error, destination untouched
        wp = '0;
        emit(i_t(77, 0, 3'b000, 10, OP_I));
        emit(i_t(2, 0, 3'b010, 10, OP_LW));
        emit(EOF_W);
        exp_v("mis_err", K_ERR, 0, 1);
        exp_v("mis_x10", K_REG, 10, 32'd77);
        exp_v("mis_ins", K_INS, 0, 32'd1);
        exp_v("mis_cyc", K_CYC, 0, 32'd7);
        run("mis");
        check_all();

        // Store past the end of DMEM halts with error
        wp = '0;
        emit(u_t(20'h00001, 12));
        emit(s_t(0, 1, 12));
        emit(EOF_W);
        exp_v("oob_err", K_ERR, 0, 1);
        exp_v("oob_ins", K_INS, 0, 32'd1);
        run("oob");
        check_all();

        // Illegal opcode
        wp = '0;
        emit(i_t(1, 0, 3'b000, 14, OP_I));
        emit(32'h0000_007F);
        emit(EOF_W);
        exp_v("ill_err", K_ERR, 0, 1);
        exp_v("ill_x14", K_REG, 14, 32'd1);
        exp_v("ill_ins", K_INS, 0, 32'd1);
        exp_v("ill_cyc", K_CYC, 0, 32'd6);
        run("ill");
        check_all();

        // Reset during MEM of a store: seed a known word first
        wp = '0;
        emit(i_t(32'h123, 0, 3'b000, 16, OP_I));
        emit(s_t(16, 16, 0));
        emit(EOF_W);
        exp_v("seed_w16", K_WORD, 16, 32'h0000_0123);
        run("seed");
        check_all();

        wp = '0;
        emit(i_t(32'h55, 0, 3'b000, 15, OP_I));
        emit(s_t(16, 15, 0));
        emit(EOF_W);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (cycle_count == 32'd7) break;
            @(negedge clk);
        end
        tot_cnt++;
        assert (cycle_count === 32'd7) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL rst_sync: got %0d expected 7", cycle_count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_v("mrst_done", K_DONE, 0, 0);
        exp_v("mrst_err",  K_ERR,  0, 0);
        exp_v("mrst_cyc",  K_CYC,  0, 0);
        exp_v("mrst_ins",  K_INS,  0, 0);
        exp_v("mrst_w16",  K_WORD, 16, 32'h0000_0123);
        exp_v("mrst_x15",  K_REG,  15, 32'd0);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        exp_v("rerun_err", K_ERR,  0, 0);
        exp_v("rerun_x15", K_REG,  15, 32'h55);
        exp_v("rerun_w16", K_WORD, 16, 32'h0000_0055);
        exp_v("rerun_ins", K_INS,  0, 32'd2);
        exp_v("rerun_cyc", K_CYC,  0, 32'd9);
        run("rerun");
        check_all();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
